quarter_dds_gen: RTL and testbench

// Parametrised quarter-wave DDS: phase accumulator + one quarter-wave ROM, 3-stage pipeline.

---
 rtl/quarter_dds_gen.sv | 124 ++++++++++++
 tb/tb_quarter_dds_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/quarter_dds_gen.sv
// Quarter-wave DDS: phase accumulator feeding a 3-stage pipeline that unfolds one
// quarter-sine ROM into full-period quadrature sine/cosine in offset binary.
module quarter_dds_gen #(
  parameter int    DATA_W    = 11,
  parameter int    QADDR_W   = 6,
  parameter int    PHASE_W   = 16,
  parameter string INIT_FILE = "quarter.mem"
) (
  input  logic               clka,
  input  logic               rst,
  input  logic               en,
  input  logic               sync,
  input  logic [PHASE_W-1:0] ftw,
  input  logic [PHASE_W-1:0] phase_off,
  output logic [DATA_W-1:0]  sin_out,
  output logic [DATA_W-1:0]  cos_out,
  output logic               out_valid
);

  localparam int AW = QADDR_W + 2;
  localparam int N  = 2 ** QADDR_W;
  localparam logic [DATA_W-1:0] MID  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] FULL = '1;
  localparam real PI = 3.14159265358979323846;

  logic [DATA_W-1:0]  rom_mem [N];
  logic [PHASE_W-1:0] acc_reg;
  logic [PHASE_W-1:0] phase_sum;
  logic [AW-1:0]      addr [2];
  logic               v1_reg, v2_reg, v3_reg;

  initial begin
    for (int i = 0; i < N; i++) begin
      rom_mem[i] = DATA_W'($rtoi(real'(MID) + real'(MID - 1'b1) *
                   $sin(PI * real'(i + 1) / (2.0 * real'(N))) + 0.5));
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (sync) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_reg + ftw;
    end
  end

  assign phase_sum = acc_reg + phase_off;
  assign addr[0]   = phase_sum[PHASE_W-1 -: AW];
  assign addr[1]   = addr[0] + AW'(N);

  generate
    if (PHASE_W > AW) begin : g_low_bits
      logic unused_phase_low;
      assign unused_phase_low = ^phase_sum[PHASE_W-AW-1:0];
    end
  endgenerate

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
    end else begin
      v1_reg <= en & ~sync;
      v2_reg <= v1_reg;
      v3_reg <= v2_reg;
    end
  end

  // Channel 0 follows the phase directly, channel 1 runs a quarter period ahead.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [1:0]         quad;
      logic [QADDR_W-1:0] kofs;
      logic [QADDR_W-1:0] idx_next;
      logic               zero_next;
      logic [1:0]         q1_reg, q2_reg;
      logic [QADDR_W-1:0] idx1_reg;
      logic               z1_reg, z2_reg;
      logic [DATA_W-1:0]  rom_q_reg;
      logic [DATA_W-1:0]  out_reg;

      assign quad      = addr[gi][AW-1 -: 2];
      assign kofs      = addr[gi][QADDR_W-1:0];
      // Rising quadrants are offset by one entry, so their k=0 point is the midpoint.
      assign zero_next = ~quad[0] && (kofs == '0);
      assign idx_next  = quad[0] ? ~kofs : kofs - 1'b1;

      always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
          q1_reg    <= '0;
          idx1_reg  <= '0;
          z1_reg    <= 1'b0;
          q2_reg    <= '0;
          z2_reg    <= 1'b0;
          rom_q_reg <= '0;
          out_reg   <= '0;
        end else begin
          q1_reg    <= quad;
          idx1_reg  <= idx_next;
          z1_reg    <= zero_next;
          q2_reg    <= q1_reg;
          z2_reg    <= z1_reg;
          rom_q_reg <= rom_mem[idx1_reg];
          if (z2_reg) begin
            out_reg <= MID;
          end else if (q2_reg[1]) begin
            out_reg <= FULL - rom_q_reg;
          end else begin
            out_reg <= rom_q_reg;
          end
        end
      end
    end
  endgenerate

  assign sin_out   = g_chan[0].out_reg;
  assign cos_out   = g_chan[1].out_reg;
  assign out_valid = v3_reg;

endmodule

// File: tb/tb_quarter_dds_gen.sv
// Bench for quarter_dds_gen: trig-based reference model with 3-edge latency,
// checked every cycle, plus directed literal checks at the waveform landmarks.
module tb_quarter_dds_gen;

  localparam int    DATA_W = 11;
  localparam int    MID    = 1024;
  localparam int    FULL   = 2047;
  localparam real   PI     = 3.14159265358979323846;

  logic        clka;
  logic        rst;
  logic        en;
  logic        sync;
  logic [15:0] ftw;
  logic [15:0] phase_off;
  logic [10:0] sin_out;
  logic [10:0] cos_out;
  logic        out_valid;

  int tests;
  int fails;
  bit started;

  quarter_dds_gen #(
    .DATA_W   (11),
    .QADDR_W  (6),
    .PHASE_W  (16),
    .INIT_FILE("")
  ) dut (
    .clka     (clka),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .ftw      (ftw),
    .phase_off(phase_off),
    .sin_out  (sin_out),
    .cos_out  (cos_out),
    .out_valid(out_valid)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_lit(input string name, input int act, input int exp);
    $display("[TB] txn %s: got %0d expected %0d", name, act, exp);
    chk(name, act, exp);
  endtask

  // Ideal waveform for an 8-bit phase: positive half by rounding, negative half as
  // the full-scale mirror of the positive value, zero crossings at exactly MID.
  function automatic int golden(input logic [7:0] a);
    real s;
    if (a[6:0] == 7'd0) return MID;
    s = $sin(2.0 * PI * real'(a) / 256.0);
    if (a < 8'd128) return $rtoi(real'(MID) + real'(MID - 1) * s + 0.5);
    return FULL - $rtoi(real'(MID) + real'(MID - 1) * (-s) + 0.5);
  endfunction

  typedef struct packed {
    logic [10:0] s;
    logic [10:0] c;
    logic        v;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_acc;

  always @(posedge clka or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_acc <= '0;
    end else begin
      logic [15:0] ph;
      logic [7:0]  a;
      ph = m_acc + phase_off;
      a  = ph[15:8];
      mq.push_back('{s: 11'(golden(a)), c: 11'(golden(a + 8'd64)), v: en & ~sync});
      if (mq.size() > 3) void'(mq.pop_front());
      if (sync)    m_acc <= '0;
      else if (en) m_acc <= m_acc + ftw;
    end
  end

  always @(negedge clka) begin
    if (started) begin
      if (rst) begin
        chk("rst_hold_sin", int'(sin_out), 0);
        chk("rst_hold_cos", int'(cos_out), 0);
        chk("rst_hold_valid", int'(out_valid), 0);
      end else if (mq.size() < 3) begin
        chk("fill_valid", int'(out_valid), 0);
      end else begin
        chk("model_valid", int'(out_valid), int'(mq[0].v));
        chk("model_sin", int'(sin_out), int'(mq[0].s));
        chk("model_cos", int'(cos_out), int'(mq[0].c));
      end
    end
  end

  task automatic sweep_landmarks(input string tag);
    int cnt;
    int first_cyc;
    cnt = 0;
    first_cyc = -1;
    for (int cyc = 0; cyc < 300 && cnt < 260; cyc++) begin
      @(negedge clka);
      if (out_valid) begin
        if (cnt == 0) begin
          first_cyc = cyc;
          chk_lit({tag, "_s0"}, int'(sin_out), 1024);
          chk_lit({tag, "_c0"}, int'(cos_out), 2047);
        end
        if (cnt == 64) begin
          chk_lit({tag, "_s64"}, int'(sin_out), 2047);
          chk_lit({tag, "_c64"}, int'(cos_out), 1024);
        end
        if (cnt == 128) begin
          chk_lit({tag, "_s128"}, int'(sin_out), 1024);
          chk_lit({tag, "_c128"}, int'(cos_out), 0);
        end
        if (cnt == 192) begin
          chk_lit({tag, "_s192"}, int'(sin_out), 0);
          chk_lit({tag, "_c192"}, int'(cos_out), 1024);
        end
        cnt++;
      end
    end
    chk_lit({tag, "_first_valid_cycle"}, first_cyc, 2);
    chk_lit({tag, "_sample_count"}, cnt, 260);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    started = 1'b0;
    rst = 1'b1;
    en = 1'b0;
    sync = 1'b0;
    ftw = '0;
    phase_off = '0;

    repeat (2) @(negedge clka);
    chk_lit("reset_sin", int'(sin_out), 0);
    chk_lit("reset_cos", int'(cos_out), 0);
    chk_lit("reset_valid", int'(out_valid), 0);
    @(negedge clka);
    rst = 1'b0;
    started = 1'b1;

    // Full-period sweep, one table step per cycle.
    en = 1'b1;
    ftw = 16'd256;
    sweep_landmarks("sweep");

    // Enable toggled 4 on / 4 off.
    for (int i = 0; i < 32; i++) begin
      en = ((i / 4) % 2) == 0;
      @(negedge clka);
    end

    // Sync with enable held high.
    en = 1'b1;
    repeat (10) @(negedge clka);
    sync = 1'b1;
    @(negedge clka);
    sync = 1'b0;
    @(negedge clka);
    @(negedge clka);
    chk_lit("sync_sample_valid", int'(out_valid), 0);
    @(negedge clka);
    chk_lit("sync_zero_sin", int'(sin_out), 1024);
    chk_lit("sync_zero_cos", int'(cos_out), 2047);
    chk_lit("sync_zero_valid", int'(out_valid), 1);

    // Quarter-period offset, frozen phase.
    sync = 1'b1;
    @(negedge clka);
    sync = 1'b0;
    ftw = 16'd0;
    phase_off = 16'h4000;
    repeat (4) @(negedge clka);
    for (int i = 0; i < 3; i++) begin
      chk_lit("off90_sin", int'(sin_out), 2047);
      chk_lit("off90_cos", int'(cos_out), 1024);
      @(negedge clka);
    end

    // Odd tuning word and offset, changed on the fly.
    ftw = 16'd1000;
    phase_off = 16'h1234;
    repeat (40) @(negedge clka);
    ftw = 16'd4321;
    repeat (20) @(negedge clka);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    chk_lit("async_rst_sin", int'(sin_out), 0);
    chk_lit("async_rst_cos", int'(cos_out), 0);
    chk_lit("async_rst_valid", int'(out_valid), 0);
    en = 1'b0;
    @(negedge clka);
    @(negedge clka);
    rst = 1'b0;
    en = 1'b1;
    ftw = 16'd256;
    phase_off = 16'd0;
    sweep_landmarks("restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
